// File: rtl/avalon_st_pkg.sv
// Shared types and default widths for the Avalon-ST packet FIFO.
package avalon_st_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 32;
    localparam int unsigned DEF_DEPTH         = 16;
    localparam int unsigned DEF_CHANNEL_WIDTH = 2;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]    data;
        logic                         sop;
        logic                         eop;
        logic [DEF_CHANNEL_WIDTH-1:0] channel;
    } beat_t;

    typedef enum logic {
        TRK_IDLE   = 1'b0,
        TRK_IN_PKT = 1'b1
    } trk_state_t;

    function automatic int unsigned beat_bits(input int unsigned dw, input int unsigned cw);
        return dw + cw + 2;
    endfunction

endpackage

// File: rtl/avalon_st_pkt_fifo_if.sv
// One Avalon-ST link; master drives the beat, slave drives ready.
interface avalon_st_pkt_fifo_if
    import avalon_st_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned CHANNEL_WIDTH = DEF_CHANNEL_WIDTH
);
    logic                     valid;
    logic                     ready;
    logic [DATA_WIDTH-1:0]    data;
    logic                     sop;
    logic                     eop;
    logic [CHANNEL_WIDTH-1:0] channel;

    modport master (output valid, output data, output sop, output eop, output channel, input ready);
    modport slave  (input valid, input data, input sop, input eop, input channel, output ready);

endinterface

// File: rtl/avalon_st_fifo_mem.sv
// Simple dual-port beat store: synchronous write, combinational read, no reset.
module avalon_st_fifo_mem
    import avalon_st_pkg::*;
#(
    parameter int unsigned WIDTH = beat_bits(DEF_DATA_WIDTH, DEF_CHANNEL_WIDTH),
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/avalon_st_pkt_fifo.sv
// Avalon-ST packet FIFO with optional store-and-forward release and a sticky
// sink-side packet protocol checker.
module avalon_st_pkt_fifo
    import avalon_st_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned CHANNEL_WIDTH = DEF_CHANNEL_WIDTH,
    parameter int unsigned STORE_FWD     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    avalon_st_pkt_fifo_if.slave     in_st,
    avalon_st_pkt_fifo_if.master    out_st,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    proto_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned BW = beat_bits(DATA_WIDTH, CHANNEL_WIDTH);
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic                     sop;
        logic                     eop;
        logic [CHANNEL_WIDTH-1:0] channel;
    } beat_p_t;

    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [PW-1:0]            w_fill;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_wr;
    logic                     w_rd;
    logic                     w_release;
    beat_p_t                  w_wr_beat;
    beat_p_t                  w_rd_beat;
    trk_state_t               r_trk_state;
    trk_state_t               w_trk_next;
    logic [CHANNEL_WIDTH-1:0] r_pkt_chan;
    logic [CHANNEL_WIDTH-1:0] w_pkt_chan_next;
    logic                     r_proto_err;
    logic                     w_viol;

    // Extra pointer MSB tells full from empty, so the level is a plain difference.
    assign w_fill  = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_fill == FULL_LVL);
    assign w_empty = (w_fill == '0);
    assign w_wr    = in_st.valid && in_st.ready;
    assign w_rd    = out_st.valid && out_st.ready;

    assign in_st.ready = !reset && !w_full;
    assign fill_level  = w_fill;
    assign proto_err   = r_proto_err;

    assign w_wr_beat = '{data: in_st.data, sop: in_st.sop, eop: in_st.eop, channel: in_st.channel};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    avalon_st_fifo_mem #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (w_wr_beat),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_beat)
    );

    assign out_st.valid   = !w_empty && w_release;
    assign out_st.data    = w_rd_beat.data;
    assign out_st.sop     = w_rd_beat.sop;
    assign out_st.eop     = w_rd_beat.eop;
    assign out_st.channel = w_rd_beat.channel;

    generate
        if (STORE_FWD != 0) begin : g_sf
            logic [PW-1:0] r_pkt_count;
            logic          w_wr_eop;
            logic          w_rd_eop;

            assign w_wr_eop = w_wr && in_st.eop;
            assign w_rd_eop = w_rd && w_rd_beat.eop;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_pkt_count <= '0;
                end else begin
                    case ({w_wr_eop, w_rd_eop})
                        2'b10:   r_pkt_count <= r_pkt_count + PW'(1);
                        2'b01:   r_pkt_count <= r_pkt_count - PW'(1);
                        default: r_pkt_count <= r_pkt_count;
                    endcase
                end
            end

            // A full FIFO releases a partial packet so oversize packets cannot deadlock.
            assign w_release = (r_pkt_count != '0) || w_full;
        end else begin : g_ct
            assign w_release = 1'b1;
        end
    endgenerate

    always_comb begin
        w_trk_next      = r_trk_state;
        w_pkt_chan_next = r_pkt_chan;
        w_viol          = 1'b0;
        if (w_wr) begin
            case (r_trk_state)
                TRK_IDLE: begin
                    w_viol = !in_st.sop;
                    if (in_st.sop && !in_st.eop) begin
                        w_trk_next      = TRK_IN_PKT;
                        w_pkt_chan_next = in_st.channel;
                    end
                end
                TRK_IN_PKT: begin
                    w_viol = in_st.sop || (in_st.channel != r_pkt_chan);
                    if (in_st.eop) w_trk_next = TRK_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trk_state <= TRK_IDLE;
            r_pkt_chan  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_trk_state <= w_trk_next;
            r_pkt_chan  <= w_pkt_chan_next;
            if (w_viol) r_proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avalon_st_pkt_fifo.sv
// Drives a cut-through and a store-and-forward FIFO side by side and checks
// both against a queue-based reference model every cycle.
module tb_avalon_st_pkt_fifo;
    import avalon_st_pkg::*;

    localparam int DW    = 32;
    localparam int CW    = 2;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic tb_rst;
    always #5 clk = ~clk;

    avalon_st_pkt_fifo_if #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW)) ct_in ();
    avalon_st_pkt_fifo_if #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW)) ct_out ();
    avalon_st_pkt_fifo_if #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW)) sf_in ();
    avalon_st_pkt_fifo_if #(.DATA_WIDTH(DW), .CHANNEL_WIDTH(CW)) sf_out ();

    logic [4:0] ct_fill, sf_fill;
    logic       ct_err, sf_err;

    avalon_st_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CHANNEL_WIDTH(CW), .STORE_FWD(0)) u_ct (
        .clk(clk), .reset(tb_rst), .in_st(ct_in), .out_st(ct_out), .fill_level(ct_fill), .proto_err(ct_err)
    );
    avalon_st_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CHANNEL_WIDTH(CW), .STORE_FWD(1)) u_sf (
        .clk(clk), .reset(tb_rst), .in_st(sf_in), .out_st(sf_out), .fill_level(sf_fill), .proto_err(sf_err)
    );

    // Index 0 = cut-through DUT, index 1 = store-and-forward DUT.
    logic          drv_valid [2];
    logic          drv_sop   [2];
    logic          drv_eop   [2];
    logic          drv_oready[2];
    logic [DW-1:0] drv_data  [2];
    logic [CW-1:0] drv_ch    [2];

    assign ct_in.valid   = drv_valid[0];
    assign ct_in.data    = drv_data[0];
    assign ct_in.sop     = drv_sop[0];
    assign ct_in.eop     = drv_eop[0];
    assign ct_in.channel = drv_ch[0];
    assign ct_out.ready  = drv_oready[0];
    assign sf_in.valid   = drv_valid[1];
    assign sf_in.data    = drv_data[1];
    assign sf_in.sop     = drv_sop[1];
    assign sf_in.eop     = drv_eop[1];
    assign sf_in.channel = drv_ch[1];
    assign sf_out.ready  = drv_oready[1];

    logic          obs_ready[2], obs_valid[2], obs_sop[2], obs_eop[2], obs_err[2];
    logic [DW-1:0] obs_data[2];
    logic [CW-1:0] obs_ch[2];
    logic [4:0]    obs_fill[2];

    assign obs_ready[0] = ct_in.ready;   assign obs_ready[1] = sf_in.ready;
    assign obs_valid[0] = ct_out.valid;  assign obs_valid[1] = sf_out.valid;
    assign obs_data[0]  = ct_out.data;   assign obs_data[1]  = sf_out.data;
    assign obs_sop[0]   = ct_out.sop;    assign obs_sop[1]   = sf_out.sop;
    assign obs_eop[0]   = ct_out.eop;    assign obs_eop[1]   = sf_out.eop;
    assign obs_ch[0]    = ct_out.channel; assign obs_ch[1]   = sf_out.channel;
    assign obs_fill[0]  = ct_fill;       assign obs_fill[1]  = sf_fill;
    assign obs_err[0]   = ct_err;        assign obs_err[1]   = sf_err;

    // Reference model: stored beats as a queue; packet tracking by the packet rules.
    beat_t         q_ct[$];
    beat_t         q_sf[$];
    bit            m_inpkt[2];
    logic [CW-1:0] m_ch[2];
    bit            m_err[2];

    bit            acc[2];
    bit            rd_fire[2];
    logic [DW-1:0] rd_data[2];
    int            pk_left[2];
    logic [CW-1:0] pk_ch[2];
    string         nm[2] = '{"ct", "sf"};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int msize(input int d);
        return (d == 0) ? q_ct.size() : q_sf.size();
    endfunction

    function automatic beat_t mhead(input int d);
        return (d == 0) ? q_ct[0] : q_sf[0];
    endfunction

    function automatic bit m_any_eop(input int d);
        if (d == 0) begin
            foreach (q_ct[i]) if (q_ct[i].eop) return 1'b1;
        end else begin
            foreach (q_sf[i]) if (q_sf[i].eop) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_ready(input int d);
        return !tb_rst && (msize(d) < DEPTH);
    endfunction

    function automatic bit exp_valid(input int d);
        return !tb_rst && (msize(d) != 0) && (d == 0 || m_any_eop(d) || msize(d) == DEPTH);
    endfunction

    task automatic model_clear();
        q_ct.delete();
        q_sf.delete();
        for (int d = 0; d < 2; d++) begin
            m_inpkt[d] = 1'b0;
            m_err[d]   = 1'b0;
            m_ch[d]    = '0;
        end
    endtask

    task automatic m_write(input int d, input beat_t b);
        if (!m_inpkt[d]) begin
            if (!b.sop) m_err[d] = 1'b1;
            else if (!b.eop) begin
                m_inpkt[d] = 1'b1;
                m_ch[d]    = b.channel;
            end
        end else begin
            if (b.sop || b.channel != m_ch[d]) m_err[d] = 1'b1;
            if (b.eop) m_inpkt[d] = 1'b0;
        end
        if (d == 0) q_ct.push_back(b);
        else        q_sf.push_back(b);
    endtask

    // Entered and left at a falling edge; checks outputs, then steps the model.
    task automatic tick();
        bit    w[2];
        bit    r[2];
        beat_t b[2];
        #1;
        if (tb_rst) model_clear();
        for (int d = 0; d < 2; d++) begin
            check_eq({nm[d], ".in_ready"},   64'(obs_ready[d]), 64'(exp_ready(d)));
            check_eq({nm[d], ".out_valid"},  64'(obs_valid[d]), 64'(exp_valid(d)));
            check_eq({nm[d], ".fill_level"}, 64'(obs_fill[d]),  64'(msize(d)));
            check_eq({nm[d], ".proto_err"},  64'(obs_err[d]),   64'(m_err[d]));
            if (exp_valid(d) && obs_valid[d]) begin
                check_eq({nm[d], ".out_data"}, 64'(obs_data[d]), 64'(mhead(d).data));
                check_eq({nm[d], ".out_sop"},  64'(obs_sop[d]),  64'(mhead(d).sop));
                check_eq({nm[d], ".out_eop"},  64'(obs_eop[d]),  64'(mhead(d).eop));
                check_eq({nm[d], ".out_chan"}, 64'(obs_ch[d]),   64'(mhead(d).channel));
            end
            b[d] = '{data: drv_data[d], sop: drv_sop[d], eop: drv_eop[d], channel: drv_ch[d]};
            w[d] = drv_valid[d] && exp_ready(d);
            r[d] = exp_valid(d) && drv_oready[d];
            if (r[d]) rd_data[d] = obs_data[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            acc[d]     = 1'b0;
            rd_fire[d] = 1'b0;
            if (!tb_rst) begin
                if (r[d]) begin
                    rd_fire[d] = 1'b1;
                    if (d == 0) void'(q_ct.pop_front());
                    else        void'(q_sf.pop_front());
                end
                if (w[d]) begin
                    acc[d] = 1'b1;
                    m_write(d, b[d]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input int d, input bit v, input logic [DW-1:0] data,
                         input bit sop, input bit eop, input logic [CW-1:0] ch);
        drv_valid[d] = v;
        drv_data[d]  = data;
        drv_sop[d]   = sop;
        drv_eop[d]   = eop;
        drv_ch[d]    = ch;
    endtask

    task automatic idle(input int d);
        drive(d, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic gen(input int d);
        if (drv_valid[d] && !acc[d]) return;
        if ($urandom_range(0, 9) < 7) begin
            if (pk_left[d] == 0) begin
                pk_left[d] = int'($urandom_range(1, 24));
                pk_ch[d]   = CW'($urandom);
                drv_sop[d] = 1'b1;
            end else begin
                drv_sop[d] = 1'b0;
            end
            pk_left[d]--;
            drv_eop[d]   = (pk_left[d] == 0);
            drv_data[d]  = DW'($urandom);
            drv_ch[d]    = pk_ch[d];
            drv_valid[d] = 1'b1;
        end else begin
            drv_valid[d] = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        tb_rst = 1'b1;
        tick();
        tb_rst = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        int k;
        int nrd;
        int idx;
        int rise;
        tb_rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            idle(d);
            drv_oready[d] = 1'b0;
            acc[d] = 1'b0;
            rd_fire[d] = 1'b0;
            rd_data[d] = '0;
            pk_left[d] = 0;
            pk_ch[d] = '0;
        end
        model_clear();
        @(negedge clk);
        tick();
        tick();
        tb_rst = 1'b0;
        #1;
        check_eq("ct.ready_after_release", 64'(obs_ready[0]), 64'(1));
        tick();

        // Fill the cut-through FIFO to DEPTH, then drain it in order.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1'b1, DW'(i), 1'b1, 1'b1, 2'd0);
            tick();
        end
        idle(0);
        tick();
        check_eq("ct.full_level", 64'(obs_fill[0]), 64'(16));
        check_eq("ct.full_ready", 64'(obs_ready[0]), 64'(0));
        drv_oready[0] = 1'b1;
        k = 0;
        for (int i = 0; i < 24 && k < 16; i++) begin
            tick();
            if (rd_fire[0]) begin
                check_eq("ct.order", 64'(rd_data[0]), 64'(k));
                k++;
            end
        end
        check_eq("ct.drain_count", 64'(k), 64'(16));

        // Continuous traffic through both FIFOs with single-beat packets.
        drv_oready[1] = 1'b1;
        nrd = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, 1'b1, DW'(100 + i), 1'b1, 1'b1, 2'd0);
            drive(1, 1'b1, DW'(100 + i), 1'b1, 1'b1, 2'd1);
            tick();
            if (rd_fire[0]) nrd++;
        end
        check_eq("ct.stream_level", 64'(obs_fill[0]), 64'(1));
        check_eq("sf.stream_level", 64'(obs_fill[1]), 64'(1));
        check_eq("ct.stream_reads", 64'(nrd), 64'(39));
        idle(0);
        idle(1);
        tick();
        tick();

        // Store-and-forward holds a packet until its eop has been written.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, DW'(200 + i), (i == 0), 1'b0, 2'd2);
            tick();
            check_eq("sf.hold_valid", 64'(obs_valid[1]), 64'(0));
        end
        idle(1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("sf.hold_valid", 64'(obs_valid[1]), 64'(0));
        end
        drive(1, 1'b1, DW'(204), 1'b0, 1'b1, 2'd2);
        tick();
        check_eq("sf.release", 64'(obs_valid[1]), 64'(1));
        idle(1);
        nrd = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rd_fire[1]) begin
                check_eq("sf.pkt_order", 64'(rd_data[1]), 64'(200 + nrd));
                nrd++;
            end
        end
        check_eq("sf.pkt_count", 64'(nrd), 64'(5));

        // Packet longer than DEPTH must be released by the full condition.
        idx = 0;
        nrd = 0;
        rise = -1;
        for (int c = 0; c < 200 && nrd < 20; c++) begin
            if (idx < 20) drive(1, 1'b1, DW'(300 + idx), (idx == 0), (idx == 19), 2'd1);
            else          idle(1);
            if (obs_valid[1] && rise < 0) rise = int'(obs_fill[1]);
            tick();
            if (acc[1]) idx++;
            if (rd_fire[1]) begin
                check_eq("sf.long_order", 64'(rd_data[1]), 64'(300 + nrd));
                nrd++;
            end
        end
        check_eq("sf.rise_level", 64'(rise), 64'(16));
        check_eq("sf.long_count", 64'(nrd), 64'(20));
        idle(1);

        // Reset with stored beats discards them at once.
        drv_oready[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(0, 1'b1, DW'(400 + i), 1'b1, 1'b1, 2'd0);
            tick();
        end
        idle(0);
        tick();
        check_eq("ct.pre_rst_level", 64'(obs_fill[0]), 64'(7));
        tb_rst = 1'b1;
        #1;
        check_eq("ct.rst_valid", 64'(obs_valid[0]), 64'(0));
        check_eq("ct.rst_level", 64'(obs_fill[0]), 64'(0));
        check_eq("ct.rst_ready", 64'(obs_ready[0]), 64'(0));
        tick();
        tb_rst = 1'b0;
        #1;
        check_eq("ct.post_rst_ready", 64'(obs_ready[0]), 64'(1));
        tick();

        // Protocol violations: duplicate sop on ct, channel change on sf.
        drive(0, 1'b1, DW'(1), 1'b1, 1'b0, 2'd0);
        drive(1, 1'b1, DW'(1), 1'b1, 1'b0, 2'd1);
        tick();
        check_eq("ct.err_clean", 64'(obs_err[0]), 64'(0));
        check_eq("sf.err_clean", 64'(obs_err[1]), 64'(0));
        drive(0, 1'b1, DW'(2), 1'b1, 1'b0, 2'd0);
        drive(1, 1'b1, DW'(2), 1'b0, 1'b0, 2'd2);
        tick();
        check_eq("ct.dup_sop_err", 64'(obs_err[0]), 64'(1));
        check_eq("sf.chan_err", 64'(obs_err[1]), 64'(1));
        idle(0);
        idle(1);
        for (int i = 0; i < 3; i++) tick();
        check_eq("ct.err_sticky", 64'(obs_err[0]), 64'(1));
        tb_rst = 1'b1;
        #1;
        check_eq("ct.err_cleared", 64'(obs_err[0]), 64'(0));
        check_eq("sf.err_cleared", 64'(obs_err[1]), 64'(0));
        tick();
        tb_rst = 1'b0;
        tick();
        drive(0, 1'b1, DW'(5), 1'b0, 1'b1, 2'd0);
        tick();
        check_eq("ct.idle_nosop_err", 64'(obs_err[0]), 64'(1));
        idle(0);
        pulse_reset();

        // Randomized packet traffic with random backpressure.
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 2; d++) begin
                gen(d);
                drv_oready[d] = ($urandom_range(0, 9) < 6);
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            idle(d);
            drv_oready[d] = 1'b1;
        end
        for (int i = 0; i < 40; i++) tick();
        check_eq("ct.final_level", 64'(obs_fill[0]), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
